tmds_channel_decoder: RTL and testbench

TMDS_CHANNEL_DECODER -- requirements
Module: tmds_channel_decoder

---
 rtl/tmds_channel_decoder.sv | 170 +++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: control-token word alignment with bitslip search,
// loss-of-lock detection and registered 8b data recovery.
module tmds_channel_decoder #(
   parameter int CTRL_LOCK      = 8,
   parameter int SEARCH_TIMEOUT = 1024,
   parameter int SLIP_WAIT      = 4,
   parameter int LOSS_TIMEOUT   = 4096
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [9:0] symbol,
   output logic       bitslip,
   output logic       locked,
   output logic       de,
   output logic [1:0] ctrl,
   output logic [7:0] data
);

   localparam int RW = (CTRL_LOCK > 1) ? $clog2(CTRL_LOCK + 1) : 1;
   localparam int TW = (SEARCH_TIMEOUT > 2) ? $clog2(SEARCH_TIMEOUT) : 1;
   localparam int SW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT + 1) : 1;
   localparam int LW = (LOSS_TIMEOUT > 2) ? $clog2(LOSS_TIMEOUT) : 1;

   localparam logic [RW-1:0] RUN_LAST  = RW'(CTRL_LOCK);
   localparam logic [TW-1:0] TMO_LAST  = TW'(SEARCH_TIMEOUT - 1);
   localparam logic [SW-1:0] SLIP_LAST = SW'(SLIP_WAIT);
   localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_TIMEOUT - 1);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      SLIP   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [RW-1:0]   run_q, run_d, run_inc;
   logic [TW-1:0]   tmo_q, tmo_d, tmo_inc;
   logic [SW-1:0]   slip_q, slip_d;
   logic [LW-1:0]   loss_q, loss_d, loss_inc;
   logic            bitslip_q, bitslip_d;
   logic            locked_q, locked_d;
   logic            de_q, de_d;
   logic [1:0]      ctrl_q, ctrl_d;
   logic [7:0]      data_q, data_d;

   logic            is_ctrl;
   logic [1:0]      tok;
   logic [7:0]      q;
   logic [7:0]      dec;

   always_comb begin
      is_ctrl = 1'b1;
      tok     = 2'b00;
      case (symbol)
         10'b1101010100: tok = 2'b00;
         10'b0010101011: tok = 2'b01;
         10'b0101010100: tok = 2'b10;
         10'b1010101011: tok = 2'b11;
         default:        is_ctrl = 1'b0;
      endcase
   end

   always_comb begin
      q      = symbol[9] ? ~symbol[7:0] : symbol[7:0];
      dec    = 8'h00;
      dec[0] = q[0];
      for (int i = 1; i < 8; i++) begin
         dec[i] = symbol[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      end
   end

   always_comb begin
      state_d   = state_q;
      run_d     = run_q;
      tmo_d     = tmo_q;
      slip_d    = slip_q;
      loss_d    = loss_q;
      bitslip_d = 1'b0;
      run_inc   = (run_q == RUN_LAST) ? run_q : run_q + 1'b1;
      tmo_inc   = (tmo_q == TMO_LAST) ? tmo_q : tmo_q + 1'b1;
      loss_inc  = (loss_q == LOSS_LAST) ? loss_q : loss_q + 1'b1;

      unique case (state_q)
         SEARCH: begin
            tmo_d = tmo_inc;
            run_d = is_ctrl ? run_inc : '0;
            // lock wins over a timeout landing on the same cycle
            if (is_ctrl && run_inc == RUN_LAST) begin
               state_d = LOCKED;
               run_d   = '0;
               tmo_d   = '0;
               loss_d  = '0;
            end else if (tmo_inc == TMO_LAST) begin
               state_d   = SLIP;
               bitslip_d = 1'b1;
               run_d     = '0;
               tmo_d     = '0;
               slip_d    = '0;
            end
         end
         SLIP: begin
            run_d = '0;
            tmo_d = '0;
            if (slip_q == SLIP_LAST) begin
               state_d = SEARCH;
               slip_d  = '0;
            end else begin
               slip_d = slip_q + 1'b1;
            end
         end
         LOCKED: begin
            if (is_ctrl) begin
               loss_d = '0;
            end else if (loss_q == LOSS_LAST) begin
               state_d = SEARCH;
               loss_d  = '0;
               run_d   = '0;
               tmo_d   = '0;
            end else begin
               loss_d = loss_inc;
            end
         end
         default: state_d = SEARCH;
      endcase
   end

   // outputs follow the next state so the lock cycle's symbol is not lost
   always_comb begin
      locked_d = (state_d == LOCKED);
      de_d     = locked_d && !is_ctrl;
      data_d   = de_d ? dec : 8'h00;
      ctrl_d   = 2'b00;
      if (locked_d) begin
         ctrl_d = is_ctrl ? tok : ctrl_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= SEARCH;
         run_q     <= '0;
         tmo_q     <= '0;
         slip_q    <= '0;
         loss_q    <= '0;
         bitslip_q <= 1'b0;
         locked_q  <= 1'b0;
         de_q      <= 1'b0;
         ctrl_q    <= 2'b00;
         data_q    <= 8'h00;
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         tmo_q     <= tmo_d;
         slip_q    <= slip_d;
         loss_q    <= loss_d;
         bitslip_q <= bitslip_d;
         locked_q  <= locked_d;
         de_q      <= de_d;
         ctrl_q    <= ctrl_d;
         data_q    <= data_d;
      end
   end

   assign bitslip = bitslip_q;
   assign locked  = locked_q;
   assign de      = de_q;
   assign ctrl    = ctrl_q;
   assign data    = data_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: lock, decode, loss,
// bitslip cadence and asynchronous reset behaviour.
module tb_tmds_channel_decoder;

   localparam logic [9:0] T00 = 10'b1101010100;
   localparam logic [9:0] T01 = 10'b0010101011;
   localparam logic [9:0] T10 = 10'b0101010100;
   localparam logic [9:0] T11 = 10'b1010101011;
   localparam logic [9:0] DSYM = 10'b0100000000;
   localparam logic [9:0] JUNK = 10'b0000011111;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [9:0] symbol;
   logic       bitslip;
   logic       locked;
   logic       de;
   logic [1:0] ctrl;
   logic [7:0] data;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int slips  = 0;

   logic [9:0] toks [4];
   int         pos [3];
   logic       lseen;
   logic       consec;
   logic       prev;

   always #5 clk = ~clk;

   tmds_channel_decoder dut (
      .clk     (clk),
      .reset_n (reset_n),
      .symbol  (symbol),
      .bitslip (bitslip),
      .locked  (locked),
      .de      (de),
      .ctrl    (ctrl),
      .data    (data)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic [9:0] s);
      symbol = s;
      @(posedge clk);
      #1;
      cyc++;
      if (bitslip) slips++;
   endtask

   task automatic release_rst();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cyc     = 0;
      slips   = 0;
   endtask

   initial begin
      toks[0] = T00;
      toks[1] = T01;
      toks[2] = T10;
      toks[3] = T11;
      reset_n = 1'b0;
      symbol  = T00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_locked", locked, 0);
      chk("rst_de", de, 0);
      chk("rst_ctrl", ctrl, 0);
      chk("rst_data", data, 0);
      chk("rst_slip", bitslip, 0);
      reset_n = 1'b1;
      cyc     = 0;

      // eight T00 tokens lock on the 8th
      for (int i = 0; i < 7; i++) step(T00);
      chk("lock_pre", locked, 0);
      step(T00);
      chk("lock_rise", locked, 1);
      chk("lock_de", de, 0);
      chk("lock_ctrl", ctrl, 0);

      // data decode paths
      step(DSYM);
      chk("dec_de", de, 1);
      chk("dec_xor0", data, 8'h00);
      step(10'b1011111111);
      chk("dec_inv", data, 8'hFE);
      step(10'b0000000001);
      chk("dec_xnor", data, 8'hFD);
      step(10'b1100000000);
      chk("dec_invxor", data, 8'h01);
      chk("dec_ctrlhold", ctrl, 2'b00);
      step(T01);
      chk("tok_de", de, 0);
      chk("tok_ctrl", ctrl, 2'b01);
      chk("tok_data", data, 0);
      step(10'b0100000001);
      chk("dec_x03", data, 8'h03);
      chk("dec_ctrl01", ctrl, 2'b01);
      chk("dec_de2", de, 1);

      // asynchronous reset while de=1
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_de", de, 0);
      chk("arst_locked", locked, 0);
      chk("arst_data", data, 0);
      chk("arst_ctrl", ctrl, 0);
      release_rst();

      // broken run, then a full run
      for (int i = 0; i < 7; i++) step(T00);
      step(JUNK);
      chk("run1_nolock", locked, 0);
      for (int i = 0; i < 7; i++) step(T00);
      chk("run2_pre", locked, 0);
      step(T00);
      chk("run2_lock", locked, 1);
      for (int i = 0; i < 4; i++) begin
         step(toks[(i + 1) % 4]);
         chk("ctrl_track", ctrl, 32'((i + 1) % 4));
         chk("ctrl_de", de, 0);
      end

      // loss of lock after 4096 data symbols
      for (int i = 0; i < 4095; i++) step(DSYM);
      chk("loss_pre_lk", locked, 1);
      chk("loss_pre_de", de, 1);
      step(DSYM);
      chk("loss_locked", locked, 0);
      chk("loss_de", de, 0);
      chk("loss_data", data, 0);
      chk("loss_noslip", slips, 0);

      // bitslip cadence on a symbol stream that never locks
      reset_n = 1'b0;
      release_rst();
      lseen  = 1'b0;
      consec = 1'b0;
      prev   = 1'b0;
      pos[0] = 0;
      pos[1] = 0;
      pos[2] = 0;
      for (int i = 0; i < 3079; i++) begin
         step(JUNK);
         if (bitslip && slips <= 3) pos[slips-1] = cyc;
         if (locked) lseen = 1'b1;
         if (bitslip && prev) consec = 1'b1;
         prev = bitslip;
      end
      chk("slip_1st", pos[0], 1023);
      chk("slip_2nd", pos[1], 2051);
      chk("slip_3rd", pos[2], 3079);
      chk("slip_count", slips, 3);
      chk("slip_nolock", lseen, 0);
      chk("slip_consec", consec, 0);
      chk("slip_now", bitslip, 1);

      // reset during the bitslip cycle, then relock from SEARCH
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_slip", bitslip, 0);
      chk("arst_lk2", locked, 0);
      release_rst();
      for (int i = 0; i < 7; i++) step(T00);
      chk("relock_pre", locked, 0);
      step(T00);
      chk("relock", locked, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
